bandai_eeprom_ctrl: RTL and testbench
=====================================

BANDAI_EEPROM_CTRL -- requirements
Module: bandai_eeprom_ctrl

Interface
REQ-001 The parameter CLKDIV SHALL default to 4 and set the CLK cycles per EE_SK half-period (legal range 1..255).
REQ-002 The parameter ADDR_BITS SHALL default to 6 and set the EEPROM word-address width, so the command length is N = 3 + ADDR_BITS bits.
REQ-003 The parameter POLL_MAX SHALL default to 4096 and set the maximum number of busy-poll samples before timeout.
REQ-004 CLK  input  1  system clock; all logic is on the rising edge.
REQ-005 RSTn  input  1  reset, asynchronous, active-low.
REQ-006 ADDR  input  8  host port address (0xC4..0xC8 decoded).
REQ-007 WR  input  1  one-cycle host write strobe.
REQ-008 RD  input  1  one-cycle host read strobe.
REQ-009 WDATA  input  8  host write data.
REQ-010 RDATA  output  8  host read data, registered.
REQ-011 EE_CS  output  1  Microwire chip select, active-high.
REQ-012 EE_SK  output  1  Microwire serial clock.
REQ-013 EE_DI  output  1  serial data to the EEPROM.
REQ-014 EE_DO  input  1  serial data from the EEPROM; it is already synchronous to CLK.

Function
REQ-015 The port map SHALL be:
- 0xC4 DATA_LO and 0xC5 DATA_HI form a 16-bit data word.
- 0xC6 CMD_LO and 0xC7 CMD_HI form a 16-bit command word; bits [N-1:0] are used, right-aligned, and sent MSB (start bit) first.
- 0xC8 CTRL: on write, bit4 READ, bit5 WRITE, bit6 SHORT; on read, bit0 READY, bit1 DONE, bit2 TIMEOUT, other bits 0.
REQ-016 On RD, RDATA SHALL present the addressed register on the next cycle; unmapped addresses SHALL return 0x00; RDATA SHALL hold between reads.
REQ-017 Writes to 0xC4..0xC8 SHALL be ignored while READY=0.
REQ-018 A CTRL write with READY=1 SHALL start an operation, with priority READ > WRITE > SHORT; a CTRL write with none of these bits set SHALL be ignored.
REQ-019 On start, the block SHALL clear DONE and TIMEOUT, set READY=0, and drive EE_CS=1 on the following cycle.
REQ-020 Each serial bit SHALL take 2*CLKDIV cycles:
- EE_SK=0 for CLKDIV cycles, then EE_SK=1 for CLKDIV cycles.
- EE_DI updates on the first cycle of the low phase.
- EE_DO is sampled on the last cycle of the high phase.
REQ-021 The state machine SHALL have states IDLE, CMD, DOUT, DIN, GAP, POLL and FINISH.
REQ-022 CMD SHALL shift out the N command bits, then go to DIN (READ), DOUT (WRITE) or FINISH (SHORT).
REQ-023 DIN SHALL clock 16 further bits and shift EE_DO samples MSB-first into {DATA_HI,DATA_LO}; the dummy 0 present before the first sample is not captured; EE_DI=0 throughout.
REQ-024 DOUT SHALL shift out {DATA_HI,DATA_LO} MSB-first (16 bits), then go to GAP.
REQ-025 GAP SHALL hold EE_CS=0 and EE_SK=0 for 2*CLKDIV cycles, then set EE_CS=1 and go to POLL.
REQ-026 POLL SHALL hold EE_SK=0 and sample EE_DO every CLKDIV cycles:
- A sample of 1 SHALL go to FINISH.
- After POLL_MAX samples of 0, the block SHALL set TIMEOUT=1 and go to FINISH.
REQ-027 FINISH SHALL drive EE_CS=0, EE_SK=0 and EE_DI=0 for one cycle, set DONE=1 and READY=1, then return to IDLE.
REQ-028 A READ with CLKDIV=4 and ADDR_BITS=6 SHALL set DONE exactly 2 + 25*8 = 202 cycles after the CTRL write cycle.
REQ-029 In IDLE, EE_CS, EE_SK and EE_DI SHALL all be 0.
REQ-030 A host RD in the same cycle as DONE rising SHALL return the pre-update status; the next RD SHALL return the updated status.

Reset
REQ-031 While RSTn=0 the block SHALL hold:
- EE_CS=0, EE_SK=0, EE_DI=0, RDATA=0x00.
- DATA, CMD=0x0000.
- READY=1, DONE=0, TIMEOUT=0, state IDLE.
REQ-032 Assertion of RSTn mid-operation SHALL abort immediately to the reset values with no completion flag set.
REQ-033 After RSTn is released, the first rising CLK edge SHALL accept host writes.

Verification
REQ-034 READ: CMD=0x0185 (start=1, op=10, addr=0x05); EEPROM model returns 0xBEEF -> EE_DI carries 1,1,0,0,0,0,1,0,1; DONE=1 at cycle 202; DATA_HI=0xBE, DATA_LO=0xEF.
REQ-035 WRITE: CMD=0x0145, DATA=0x1234; model busy for 10 samples -> DI stream is 9 command bits then 0x1234 MSB-first; GAP lasts 8 cycles; DONE=1 and TIMEOUT=0 after the 11th poll sample.
REQ-036 Timeout: POLL_MAX=16, EE_DO stuck at 0 during WRITE -> TIMEOUT=1, DONE=1, READY=1, EE_CS=0.
REQ-037 Busy lockout: write DATA_LO=0xAA while READY=0 -> DATA_LO unchanged; a second CTRL write does not restart the operation.
REQ-038 SHORT: CMD=0x0130 (EWEN) -> exactly 9 SK pulses, no GAP or POLL, DONE=1 at cycle 2 + 9*8 = 74.
REQ-039 Reset mid-READ at cycle 50 -> outputs at reset values in the same cycle; READY=1, DONE=0; a subsequent READ completes normally.

Source files
------------

// File: rtl/bandai_eeprom_ctrl.sv
// Host-port bridge to a Microwire (93Cxx-style) serial EEPROM: command, read,
// write-with-busy-poll and short (command-only) operations behind five byte registers.
module bandai_eeprom_ctrl #(
  parameter int CLKDIV    = 4,
  parameter int ADDR_BITS = 6,
  parameter int POLL_MAX  = 4096
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] ADDR,
  input  logic       WR,
  input  logic       RD,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       EE_CS,
  output logic       EE_SK,
  output logic       EE_DI,
  input  logic       EE_DO,
  output logic [2:0] dbg_state
);

  localparam int N    = 3 + ADDR_BITS;
  localparam int LAST = 2 * CLKDIV - 1;
  localparam int CW   = 9;
  localparam int PW   = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    DOUT   = 3'd2,
    DIN    = 3'd3,
    GAP    = 3'd4,
    POLL   = 3'd5,
    FINISH = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SHORT = 2'd2
  } op_t;

  state_t          state;
  op_t             op;
  logic [15:0]     data_q;
  logic [15:0]     cmd_q;
  logic [15:0]     sh;
  logic [4:0]      bits_left;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   poll_cnt;
  logic            ready;
  logic            done;
  logic            timeout;

  logic bit_end;
  logic half_end;
  logic serial;

  // cnt indexes the cycle within a bit: low phase 0..CLKDIV-1, high phase after.
  assign bit_end   = (cnt == CW'(LAST));
  assign half_end  = (cnt == CW'(CLKDIV - 1));
  assign serial    = (state == CMD) || (state == DOUT) || (state == DIN);
  assign dbg_state = state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      op        <= OP_READ;
      data_q    <= 16'h0000;
      cmd_q     <= 16'h0000;
      sh        <= 16'h0000;
      bits_left <= 5'd0;
      cnt       <= '0;
      poll_cnt  <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      timeout   <= 1'b0;
      EE_CS     <= 1'b0;
      EE_SK     <= 1'b0;
      EE_DI     <= 1'b0;
      RDATA     <= 8'h00;
    end else begin
      // Status reads see the registers as they were before this edge.
      if (RD) begin
        case (ADDR)
          8'hC4:   RDATA <= data_q[7:0];
          8'hC5:   RDATA <= data_q[15:8];
          8'hC6:   RDATA <= cmd_q[7:0];
          8'hC7:   RDATA <= cmd_q[15:8];
          8'hC8:   RDATA <= {5'b00000, timeout, done, ready};
          default: RDATA <= 8'h00;
        endcase
      end

      if (serial) begin
        if (bit_end) begin
          cnt   <= '0;
          EE_SK <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
          if (half_end) EE_SK <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (WR && ready) begin
            case (ADDR)
              8'hC4: data_q[7:0]  <= WDATA;
              8'hC5: data_q[15:8] <= WDATA;
              8'hC6: cmd_q[7:0]   <= WDATA;
              8'hC7: cmd_q[15:8]  <= WDATA;
              8'hC8: begin
                if (WDATA[6:4] != 3'b000) begin
                  op        <= WDATA[4] ? OP_READ : (WDATA[5] ? OP_WRITE : OP_SHORT);
                  ready     <= 1'b0;
                  done      <= 1'b0;
                  timeout   <= 1'b0;
                  state     <= CMD;
                  EE_CS     <= 1'b1;
                  EE_SK     <= 1'b0;
                  EE_DI     <= 1'b0;
                  sh        <= cmd_q << (16 - N);
                  bits_left <= 5'(N);
                  // One setup cycle with CS high before the first bit's low phase.
                  cnt       <= CW'(LAST);
                end
              end
              default: ;
            endcase
          end
        end

        CMD: begin
          if (bit_end) begin
            if (bits_left != 5'd0) begin
              EE_DI     <= sh[15];
              sh        <= {sh[14:0], 1'b0};
              bits_left <= bits_left - 1'b1;
            end else begin
              case (op)
                OP_READ: begin
                  state     <= DIN;
                  EE_DI     <= 1'b0;
                  bits_left <= 5'd16;
                end
                OP_WRITE: begin
                  state     <= DOUT;
                  EE_DI     <= data_q[15];
                  data_q    <= {data_q[14:0], data_q[15]};
                  bits_left <= 5'd16;
                end
                default: begin
                  state <= FINISH;
                  EE_CS <= 1'b0;
                  EE_DI <= 1'b0;
                end
              endcase
            end
          end
        end

        DIN: begin
          if (bit_end) begin
            data_q <= {data_q[14:0], EE_DO};
            if (bits_left == 5'd1) begin
              state <= FINISH;
              EE_CS <= 1'b0;
              EE_DI <= 1'b0;
            end else begin
              bits_left <= bits_left - 1'b1;
            end
          end
        end

        DOUT: begin
          // Rotating rather than shifting leaves DATA intact after 16 bits.
          if (bit_end) begin
            if (bits_left == 5'd1) begin
              state <= GAP;
              EE_CS <= 1'b0;
              EE_DI <= 1'b0;
            end else begin
              EE_DI     <= data_q[15];
              data_q    <= {data_q[14:0], data_q[15]};
              bits_left <= bits_left - 1'b1;
            end
          end
        end

        GAP: begin
          if (bit_end) begin
            state    <= POLL;
            EE_CS    <= 1'b1;
            cnt      <= '0;
            poll_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        POLL: begin
          if (half_end) begin
            cnt <= '0;
            if (EE_DO) begin
              state <= FINISH;
              EE_CS <= 1'b0;
            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
              timeout <= 1'b1;
              state   <= FINISH;
              EE_CS   <= 1'b0;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        FINISH: begin
          state <= IDLE;
          done  <= 1'b1;
          ready <= 1'b1;
          EE_CS <= 1'b0;
          EE_SK <= 1'b0;
          EE_DI <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bandai_eeprom_ctrl.sv
// Bench for bandai_eeprom_ctrl: host-port driver, Microwire EEPROM model and a
// scoreboard of expected EE_DI bits checked on every SK rise.
module tb_bandai_eeprom_ctrl;

  localparam int CLKDIV = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ee_cs;
  logic       ee_sk;
  logic       ee_di;
  logic       ee_do;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];

  bandai_eeprom_ctrl #(.CLKDIV(CLKDIV), .ADDR_BITS(6), .POLL_MAX(16)) dut (
    .CLK(clk), .RSTn(rst_n), .ADDR(addr), .WR(wr), .RD(rd), .WDATA(wdata),
    .RDATA(rdata), .EE_CS(ee_cs), .EE_SK(ee_sk), .EE_DI(ee_di), .EE_DO(ee_do),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // EEPROM model
  localparam int M_IDLE = 0, M_GAP = 1, M_POLL = 2;
  int          m_mode;
  int          rise_cnt;
  int          gap_cnt;
  int          poll_cyc;
  int          poll_entries;
  int          busy_samples;
  int          exp_rises;
  logic [8:0]  cmd_rx;
  logic [15:0] mem_word;
  logic        prev_sk;
  logic        prev_cs;
  logic [15:0] exp_bit;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode   = M_IDLE;
      rise_cnt = 0;
      cmd_rx   = '0;
      ee_do    = 1'b0;
      prev_sk  = 1'b0;
      prev_cs  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (ee_cs && ee_sk && !prev_sk) begin
            rise_cnt++;
            exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            check($sformatf("di_bit%0d", rise_cnt), {15'd0, ee_di}, exp_bit);
            if (rise_cnt <= 9) cmd_rx = {cmd_rx[7:0], ee_di};
            if (rise_cnt == 9) ee_do = 1'b0;
            else if (rise_cnt > 9 && cmd_rx[7:6] == 2'b10 && rise_cnt <= 25)
              ee_do = mem_word[25 - rise_cnt];
          end else if (!ee_cs && prev_cs) begin
            check("sk_rises", rise_cnt, exp_rises);
            if (rise_cnt == 25 && cmd_rx[7:6] == 2'b01) begin
              m_mode  = M_GAP;
              gap_cnt = 1;
            end
            rise_cnt = 0;
            cmd_rx   = '0;
            ee_do    = 1'b0;
          end
        end
        M_GAP: begin
          if (!ee_cs) gap_cnt++;
          else begin
            check("gap_len", gap_cnt, 2 * CLKDIV);
            check("gap_sk", {31'd0, ee_sk}, 0);
            m_mode   = M_POLL;
            poll_entries++;
            poll_cyc = 1;
            ee_do    = (poll_cyc > busy_samples * CLKDIV);
          end
        end
        default: begin
          if (ee_cs) begin
            poll_cyc++;
            ee_do = (poll_cyc > busy_samples * CLKDIV);
          end else begin
            m_mode = M_IDLE;
            ee_do  = 1'b0;
          end
        end
      endcase
      prev_sk = ee_sk;
      prev_cs = ee_cs;
    end
  end

  // host driver tasks
  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
    addr = a;
    rd   = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
    d = rdata;
  endtask

  task automatic push_bits(input logic [15:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back({15'd0, v[i]});
  endtask

  // Start an operation and return the edge index (CTRL write edge = 0) at which DONE rose.
  task automatic run_op(input logic [7:0] ctrl, input bit lockout, output int done_cyc);
    int n;
    bit first;
    host_wr(8'hC8, ctrl);
    n = 0;
    if (lockout) begin
      host_wr(8'hC4, 8'hAA);
      host_wr(8'hC8, 8'h10);
      n = 2;
    end
    done_cyc = -1;
    first = 1'b1;
    while (n < 2000) begin
      addr = 8'hC8;
      rd   = 1'b1;
      @(posedge clk);
      n++;
      #1 rd = 1'b0;
      if (first) begin
        check("busy_status", {24'd0, rdata}, 32'h00);
        first = 1'b0;
      end
      if (rdata[1]) begin
        done_cyc = n - 1;
        break;
      end
    end
    check("di_q_left", exp_q.size(), 0);
  endtask

  logic [7:0] r;
  int         dc;

  initial begin
    addr = 8'h00; wdata = 8'h00; wr = 1'b0; rd = 1'b0; ee_do = 1'b0;
    poll_entries = 0; busy_samples = 10; exp_rises = 25; mem_word = 16'h0000;
    m_mode = M_IDLE; rise_cnt = 0; cmd_rx = '0; prev_sk = 1'b0; prev_cs = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", {31'd0, ee_cs}, 0);
    check("rst_sk", {31'd0, ee_sk}, 0);
    check("rst_di", {31'd0, ee_di}, 0);
    check("rst_rdata", {24'd0, rdata}, 0);
    check("rst_state", {29'd0, dbg_state}, 0);
    @(negedge clk) rst_n = 1'b1;
    host_rd(8'hC8, r); check("rst_ctrl", {24'd0, r}, 32'h01);
    host_rd(8'hC5, r); check("rst_data_hi", {24'd0, r}, 32'h00);
    host_rd(8'hC7, r); check("rst_cmd_hi", {24'd0, r}, 32'h00);

    // READ with all op bits set: READ wins
    host_wr(8'hC6, 8'h85);
    host_wr(8'hC7, 8'h01);
    host_rd(8'hC6, r); check("cmd_lo_rb", {24'd0, r}, 32'h85);
    mem_word = 16'hBEEF;
    push_bits(16'h0185, 9);
    push_bits(16'h0000, 16);
    exp_rises = 25;
    run_op(8'h70, 1'b0, dc);
    check("read_done_cyc", dc, 202);
    host_rd(8'hC8, r); check("read_status", {24'd0, r}, 32'h03);
    host_rd(8'hC5, r); check("read_data_hi", {24'd0, r}, 32'hBE);
    host_rd(8'hC4, r); check("read_data_lo", {24'd0, r}, 32'hEF);
    repeat (3) @(posedge clk);
    #1 check("rdata_hold", {24'd0, rdata}, 32'hEF);
    host_rd(8'hC9, r); check("unmapped", {24'd0, r}, 32'h00);
    check("poll_none", poll_entries, 0);

    // WRITE with busy lockout attempts
    host_wr(8'hC4, 8'h34);
    host_wr(8'hC5, 8'h12);
    host_wr(8'hC6, 8'h45);
    busy_samples = 10;
    push_bits(16'h0145, 9);
    push_bits(16'h1234, 16);
    run_op(8'h20, 1'b1, dc);
    check("write_done_cyc", dc, 254);
    host_rd(8'hC8, r); check("write_status", {24'd0, r}, 32'h03);
    host_rd(8'hC4, r); check("lockout_data_lo", {24'd0, r}, 32'h34);
    host_rd(8'hC5, r); check("write_data_hi", {24'd0, r}, 32'h12);
    check("poll_one", poll_entries, 1);

    // WRITE with EE_DO stuck low -> timeout
    busy_samples = 100000;
    push_bits(16'h0145, 9);
    push_bits(16'h1234, 16);
    run_op(8'h20, 1'b0, dc);
    check("to_done_cyc", dc, 274);
    host_rd(8'hC8, r); check("to_status", {24'd0, r}, 32'h07);
    check("to_cs", {31'd0, ee_cs}, 0);

    // SHORT (EWEN): command only
    host_wr(8'hC6, 8'h30);
    push_bits(16'h0130, 9);
    exp_rises = 9;
    run_op(8'h40, 1'b0, dc);
    check("short_done_cyc", dc, 74);
    host_rd(8'hC8, r); check("short_status", {24'd0, r}, 32'h03);
    check("short_no_poll", poll_entries, 2);

    // CTRL write without op bits is ignored
    host_wr(8'hC8, 8'h0F);
    repeat (4) @(posedge clk);
    #1 check("noop_cs", {31'd0, ee_cs}, 0);
    host_rd(8'hC8, r); check("noop_status", {24'd0, r}, 32'h03);

    // Reset mid-READ at cycle 50
    host_wr(8'hC6, 8'h85);
    mem_word = 16'hBEEF;
    push_bits(16'h0185, 9);
    push_bits(16'h0000, 16);
    exp_rises = 25;
    host_wr(8'hC8, 8'h10);
    repeat (49) @(posedge clk);
    #1 check("mid_cs", {31'd0, ee_cs}, 1);
    rst_n = 1'b0;
    #1;
    check("abort_cs", {31'd0, ee_cs}, 0);
    check("abort_sk", {31'd0, ee_sk}, 0);
    check("abort_di", {31'd0, ee_di}, 0);
    check("abort_rdata", {24'd0, rdata}, 0);
    check("abort_state", {29'd0, dbg_state}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    host_rd(8'hC8, r); check("abort_status", {24'd0, r}, 32'h01);
    host_rd(8'hC6, r); check("abort_cmd_lo", {24'd0, r}, 32'h00);
    host_wr(8'hC6, 8'h85);
    host_wr(8'hC7, 8'h01);
    push_bits(16'h0185, 9);
    push_bits(16'h0000, 16);
    run_op(8'h10, 1'b0, dc);
    check("reread_done_cyc", dc, 202);
    host_rd(8'hC5, r); check("reread_data_hi", {24'd0, r}, 32'hBE);
    host_rd(8'hC4, r); check("reread_data_lo", {24'd0, r}, 32'hEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
